// File: rtl/synth_pkg.sv
// Shared types and constants for the synth control path: allocator FSM states,
// waveform codes, and the equal-tempered note-to-pitch-word table.
package synth_pkg;

  localparam int SYN_NOTE_W = 7;
  localparam int SYN_C      = 14;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    COMMIT
  } alloc_state_t;

  localparam logic [1:0] WAVE_SQUARE = 2'd0;
  localparam logic [1:0] WAVE_SAW    = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;
  localparam logic [1:0] WAVE_NOISE  = 2'd3;

  // Top octave (notes 120..131) holds round(8192 * 2^(k/12)); lower octaves halve per step.
  function automatic logic [13:0] pitch_word(input logic [6:0] note);
    logic [3:0]  oct;
    logic [3:0]  semi;
    logic [13:0] base;
    oct  = 4'(note / 7'd12);
    semi = 4'(note % 7'd12);
    case (semi)
      4'd0:    base = 14'd8192;
      4'd1:    base = 14'd8679;
      4'd2:    base = 14'd9195;
      4'd3:    base = 14'd9742;
      4'd4:    base = 14'd10321;
      4'd5:    base = 14'd10935;
      4'd6:    base = 14'd11585;
      4'd7:    base = 14'd12274;
      4'd8:    base = 14'd13004;
      4'd9:    base = 14'd13777;
      4'd10:   base = 14'd14596;
      default: base = 14'd15464;
    endcase
    return base >> (4'd10 - oct);
  endfunction

endpackage

// File: rtl/pitch_rom.sv
// 128-entry note-to-pitch ROM with a single registered read port.
// Data for address presented before edge n is valid after edge n.
module pitch_rom
  import synth_pkg::*;
#(
  parameter int C      = SYN_C,
  parameter int NOTE_W = SYN_NOTE_W
) (
  input  logic              clk,
  input  logic [NOTE_W-1:0] addr,
  output logic [C-1:0]      data
);

  logic [C-1:0] data_q;
  logic [C-1:0] data_d;

  always_comb data_d = C'(pitch_word(7'(addr)));

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/voice_allocator.sv
// Assigns note-on/off events to NUM synth channels (retrigger, free slot, or steal oldest).
// Accept at edge k, outputs update at edge k+2; one event per 3 cycles, panic aborts in-flight work.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM    = 4,
  parameter int C      = SYN_C,
  parameter int NOTE_W = SYN_NOTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              note_valid,
  output logic              note_ready,
  input  logic              note_on,
  input  logic [NOTE_W-1:0] note_num,
  input  logic [1:0]        note_wave,
  input  logic              panic,
  output logic [NUM*C-1:0]  pitches,
  output logic [NUM-1:0]    channel_ena,
  output logic [NUM*2-1:0]  waveforms
);

  localparam int AGE_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM - 1);

  alloc_state_t state_q, state_d;
  logic ready_q, ready_d;
  logic ev_on_q, ev_on_d;
  logic [NOTE_W-1:0] ev_note_q, ev_note_d;
  logic [1:0] ev_wave_q, ev_wave_d;

  logic [NUM-1:0]                ena_q, ena_d;
  logic [NUM-1:0][C-1:0]         pitch_q, pitch_d;
  logic [NUM-1:0][1:0]           wave_q, wave_d;
  logic [NUM-1:0][NOTE_W-1:0]    tag_q, tag_d;
  logic [NUM-1:0][AGE_W-1:0]     age_q, age_d;

  logic [C-1:0] rom_dat;

  logic             hit, has_free;
  logic [AGE_W-1:0] hit_idx, free_idx, old_idx, slot;
  logic [AGE_W-1:0] oldest_age;
  logic [AGE_W:0]   old_age;

  pitch_rom #(.C(C), .NOTE_W(NOTE_W)) u_pitch_rom (
    .clk  (clk),
    .addr (ev_note_q),
    .data (rom_dat)
  );

  // Candidate slots; descending scans make the lowest index win.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    has_free   = 1'b0;
    free_idx   = '0;
    old_idx    = '0;
    oldest_age = age_q[0];
    for (int i = NUM - 1; i >= 0; i--) begin
      if (ena_q[i] && (tag_q[i] == ev_note_q)) begin
        hit     = 1'b1;
        hit_idx = AGE_W'(i);
      end
      if (!ena_q[i]) begin
        has_free = 1'b1;
        free_idx = AGE_W'(i);
      end
    end
    for (int i = 1; i < NUM; i++) begin
      if (age_q[i] > oldest_age) begin
        oldest_age = age_q[i];
        old_idx    = AGE_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ev_on_d   = ev_on_q;
    ev_note_d = ev_note_q;
    ev_wave_d = ev_wave_q;
    ena_d     = ena_q;
    pitch_d   = pitch_q;
    wave_d    = wave_q;
    tag_d     = tag_q;
    age_d     = age_q;
    slot      = hit ? hit_idx : (has_free ? free_idx : old_idx);
    old_age   = (hit || !has_free) ? {1'b0, age_q[slot]} : (AGE_W + 1)'(NUM);

    case (state_q)
      IDLE: begin
        if (note_valid && ready_q) begin
          ev_on_d   = note_on;
          ev_note_d = note_num;
          ev_wave_d = note_wave;
          state_d   = LOOKUP;
        end
      end
      LOOKUP: state_d = COMMIT;
      COMMIT: begin
        state_d = IDLE;
        if (ev_on_q) begin
          for (int j = 0; j < NUM; j++) begin
            if ((AGE_W'(j) != slot) && ena_q[j] && ({1'b0, age_q[j]} < old_age)
                && (age_q[j] != AGE_MAX)) begin
              age_d[j] = age_q[j] + 1'b1;
            end
          end
          ena_d[slot]   = 1'b1;
          tag_d[slot]   = ev_note_q;
          pitch_d[slot] = rom_dat;
          wave_d[slot]  = ev_wave_q;
          age_d[slot]   = '0;
        end else if (hit) begin
          ena_d[hit_idx] = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);

    if (panic) begin
      ena_d   = '0;
      age_d   = '0;
      state_d = IDLE;
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      ev_on_q   <= 1'b0;
      ev_note_q <= '0;
      ev_wave_q <= WAVE_SQUARE;
      ena_q     <= '0;
      pitch_q   <= '0;
      wave_q    <= '0;
      tag_q     <= '0;
      age_q     <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      ev_on_q   <= ev_on_d;
      ev_note_q <= ev_note_d;
      ev_wave_q <= ev_wave_d;
      ena_q     <= ena_d;
      pitch_q   <= pitch_d;
      wave_q    <= wave_d;
      tag_q     <= tag_d;
      age_q     <= age_d;
    end
  end

  assign note_ready  = ready_q;
  assign channel_ena = ena_q;
  assign pitches     = pitch_q;
  assign waveforms   = wave_q;

endmodule
